// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA raster timing generator. Two counters walk the raster
// (active, front porch, sync, back porch per axis). A decode register turns
// the counter state into sync, blanking, coordinates and strobes, and
// PIPE_DELAY further register stages delay every output by the same number
// of pixel ticks. All state advances only on clk edges where pix_ce=1.
//
// Optional feature macro: VGA_LINE_REQ_EN
//   When defined, adds parameter LINE_LEAD and the outputs line_req /
//   line_req_y. line_req fires LINE_LEAD ticks ahead of each active line's
//   line_start, and line_req_y names the row that line will show.
//
// Ports:
//   clk          pixel-domain clock
//   reset        synchronous, active-high reset
//   pix_ce       pixel tick qualifier
//   enable       run enable; low holds the raster at the origin
//   hsync/vsync  sync outputs, active level H_POL / V_POL
//   de           data enable (active region)
//   x, y         active column/row, 0 outside the active region
//   hblank       horizontal blanking flag
//   vblank       vertical blanking flag
//   line_start   one-clk strobe at the first pixel of each active line
//   frame_start  one-clk strobe at pixel (0,0)
//   line_req     (VGA_LINE_REQ_EN) one-clk line fetch request
//   line_req_y   (VGA_LINE_REQ_EN) row requested by the last line_req
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter logic        H_POL      = 1'b0,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter logic        V_POL      = 1'b0,
    parameter int unsigned CW         = 11,
    parameter int unsigned PIPE_DELAY = 0
`ifdef VGA_LINE_REQ_EN
    ,
    parameter int unsigned LINE_LEAD  = 8
`endif
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_ce,
    input  logic          enable,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          hblank,
    output logic          vblank,
    output logic          line_start,
    output logic          frame_start
`ifdef VGA_LINE_REQ_EN
    ,
    output logic          line_req,
    output logic [CW-1:0] line_req_y
`endif
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Elaboration-time parameter checks
    if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_err_zero
        $error("vga_timing_gen: porch and sync widths must be non-zero");
    end
    if ((longint'(1) << CW) < longint'(H_TOTAL) ||
        (longint'(1) << CW) < longint'(V_TOTAL)) begin : g_err_cw
        $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
    end
    if (PIPE_DELAY > 15) begin : g_err_pipe
        $error("vga_timing_gen: PIPE_DELAY must be 0..15");
    end
`ifdef VGA_LINE_REQ_EN
    if (LINE_LEAD == 0 || LINE_LEAD > H_TOTAL - H_ACTIVE) begin : g_err_lead
        $error("vga_timing_gen: LINE_LEAD must be 1..H_TOTAL-H_ACTIVE");
    end
`endif

    localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] H_SS   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SE   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_SS   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SE   = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
`ifdef VGA_LINE_REQ_EN
    localparam logic [CW-1:0] H_REQ  = CW'(H_TOTAL - LINE_LEAD);
`endif

    typedef struct packed {
        logic          hsync;
        logic          vsync;
        logic          de;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          hblank;
        logic          vblank;
        logic          line_start;
        logic          frame_start;
`ifdef VGA_LINE_REQ_EN
        logic          line_req;
        logic [CW-1:0] line_req_y;
`endif
    } stage_t;

    function automatic stage_t idle_stage();
        stage_t s;
        s        = '0;
        s.hsync  = ~H_POL;
        s.vsync  = ~V_POL;
        s.hblank = 1'b1;
        s.vblank = 1'b1;
        return s;
    endfunction

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic          h_last;
    logic          v_last;
    logic          h_act;
    logic          v_act;
    logic          ce_seen;
    stage_t        dec_nxt;
    stage_t        stg [0:PIPE_DELAY];

    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);
    assign h_act  = (h_cnt < H_ACT);
    assign v_act  = (v_cnt < V_ACT);

    // Raster counters
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_ce) begin
            if (!enable) begin
                h_cnt <= '0;
                v_cnt <= '0;
            end else if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // Decode of the current counter state
    always_comb begin
        logic [CW-1:0] req_v;
        dec_nxt = idle_stage();
        req_v   = v_last ? '0 : v_cnt + 1'b1;
        if (enable) begin
            dec_nxt.hsync       = (h_cnt >= H_SS && h_cnt < H_SE) ? H_POL : ~H_POL;
            dec_nxt.vsync       = (v_cnt >= V_SS && v_cnt < V_SE) ? V_POL : ~V_POL;
            dec_nxt.de          = h_act && v_act;
            dec_nxt.x           = (h_act && v_act) ? h_cnt : '0;
            dec_nxt.y           = (h_act && v_act) ? v_cnt : '0;
            dec_nxt.hblank      = !h_act;
            dec_nxt.vblank      = !v_act;
            dec_nxt.line_start  = (h_cnt == '0) && v_act;
            dec_nxt.frame_start = (h_cnt == '0) && (v_cnt == '0);
        end
`ifdef VGA_LINE_REQ_EN
        // The request row is the line after the current one, so the
        // request for line 0 comes out of the last line of the frame.
        dec_nxt.line_req_y = stg[0].line_req_y;
        if (enable && h_cnt == H_REQ && req_v < V_ACT) begin
            dec_nxt.line_req   = 1'b1;
            dec_nxt.line_req_y = req_v;
        end
`else
        req_v = '0;
`endif
    end

    // Decode register followed by PIPE_DELAY delay stages
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i <= PIPE_DELAY; i++) begin
                stg[i] <= idle_stage();
            end
        end else if (pix_ce) begin
            stg[0] <= dec_nxt;
            for (int unsigned i = 1; i <= PIPE_DELAY; i++) begin
                stg[i] <= stg[i-1];
            end
        end
    end

    // Strobe bits stay held in the stages so they survive sparse pix_ce;
    // they only reach the outputs in the clk cycle right after a tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            ce_seen <= 1'b0;
        end else begin
            ce_seen <= pix_ce;
        end
    end

    assign hsync       = stg[PIPE_DELAY].hsync;
    assign vsync       = stg[PIPE_DELAY].vsync;
    assign de          = stg[PIPE_DELAY].de;
    assign x           = stg[PIPE_DELAY].x;
    assign y           = stg[PIPE_DELAY].y;
    assign hblank      = stg[PIPE_DELAY].hblank;
    assign vblank      = stg[PIPE_DELAY].vblank;
    assign line_start  = stg[PIPE_DELAY].line_start & ce_seen;
    assign frame_start = stg[PIPE_DELAY].frame_start & ce_seen;
`ifdef VGA_LINE_REQ_EN
    assign line_req    = stg[PIPE_DELAY].line_req & ce_seen;
    assign line_req_y  = stg[PIPE_DELAY].line_req_y;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

    localparam int HT = 15;
    localparam int VT = 8;
    localparam int FT = HT * VT;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pix_ce = 1'b0;
    logic enable = 1'b0;

    logic       hs0, vs0, de0, hb0, vb0, ls0, fs0;
    logic [3:0] x0, y0;
    logic       hs3, vs3, de3, hb3, vb3, ls3, fs3;
    logic [3:0] x3, y3;
`ifdef VGA_LINE_REQ_EN
    logic       lr0, lr3;
    logic [3:0] lry0, lry3;
`endif

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .H_POL(1'b0),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .V_POL(1'b0),
        .CW(4), .PIPE_DELAY(0)
`ifdef VGA_LINE_REQ_EN
        , .LINE_LEAD(4)
`endif
    ) dut0 (
        .clk(clk), .reset(reset), .pix_ce(pix_ce), .enable(enable),
        .hsync(hs0), .vsync(vs0), .de(de0), .x(x0), .y(y0),
        .hblank(hb0), .vblank(vb0), .line_start(ls0), .frame_start(fs0)
`ifdef VGA_LINE_REQ_EN
        , .line_req(lr0), .line_req_y(lry0)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .H_POL(1'b0),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .V_POL(1'b0),
        .CW(4), .PIPE_DELAY(3)
`ifdef VGA_LINE_REQ_EN
        , .LINE_LEAD(4)
`endif
    ) dut3 (
        .clk(clk), .reset(reset), .pix_ce(pix_ce), .enable(enable),
        .hsync(hs3), .vsync(vs3), .de(de3), .x(x3), .y(y3),
        .hblank(hb3), .vblank(vb3), .line_start(ls3), .frame_start(fs3)
`ifdef VGA_LINE_REQ_EN
        , .line_req(lr3), .line_req_y(lry3)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Output vector layout: {hs, vs, de, x[3:0], y[3:0], hb, vb, ls, fs}
    function automatic logic [14:0] mk(logic hs, logic vs, logic de, int xv, int yv,
                                       logic hb, logic vb, logic ls, logic fs);
        logic [3:0] xx, yy;
        xx = 4'(xv);
        yy = 4'(yv);
        return {hs, vs, de, xx, yy, hb, vb, ls, fs};
    endfunction

    localparam logic [14:0] IDLE = 15'b110_0000_0000_1100;

    // Reference: the frame is a linear sequence of FT pixel positions
    function automatic logic [14:0] ref_decode(int p);
        int h, v;
        logic act;
        h   = p % HT;
        v   = p / HT;
        act = (h < 8) && (v < 4);
        return mk(!(h >= 10 && h < 13), !(v >= 5 && v < 7), act,
                  act ? h : 0, act ? v : 0, h >= 8, v >= 4,
                  (h == 0) && (v < 4), p == 0);
    endfunction

    int          pos = 0;
    logic [14:0] hist [4];
    logic        mfired = 1'b0;
    logic        m_req = 1'b0;
    int          m_req_y = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [14:0] masked(logic [14:0] v);
        logic [14:0] r;
        r = v;
        if (!mfired) r[1:0] = 2'b00;
        return r;
    endfunction

    function automatic logic [14:0] out0();
        return {hs0, vs0, de0, x0, y0, hb0, vb0, ls0, fs0};
    endfunction

    function automatic logic [14:0] out3();
        return {hs3, vs3, de3, x3, y3, hb3, vb3, ls3, fs3};
    endfunction

    task automatic step(input logic r, input logic ce, input logic en);
        logic [14:0] rec;
        int p2;
        reset  = r;
        pix_ce = ce;
        enable = en;
        @(posedge clk);
        if (r) begin
            pos = 0;
            for (int k = 0; k < 4; k++) hist[k] = IDLE;
            mfired  = 1'b0;
            m_req   = 1'b0;
            m_req_y = 0;
        end else begin
            mfired = ce;
            if (ce) begin
                rec = en ? ref_decode(pos) : IDLE;
                for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = rec;
                p2    = (pos + 4) % FT;
                m_req = en && (p2 % HT == 0) && (p2 / HT < 4);
                if (m_req) m_req_y = p2 / HT;
                pos = en ? (pos + 1) % FT : 0;
            end
        end
        #1;
        chk("model_delay0", 32'(out0()), 32'(masked(hist[0])));
        chk("model_delay3", 32'(out3()), 32'(masked(hist[3])));
`ifdef VGA_LINE_REQ_EN
        chk("line_req", 32'(lr0), 32'(m_req & mfired));
        chk("line_req_y", 32'(lry0), 32'(m_req_y));
`endif
    endtask

    typedef struct {
        logic        r;
        logic        ce;
        logic        en;
        logic [14:0] exp;
        string       name;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fs_first, fs_second, de_cnt, fs_cnt, ls_cnt, lr_cnt, idle_bad;
        logic [14:0] hs_pat;
        logic r, ce, en;

        for (int k = 0; k < 4; k++) hist[k] = IDLE;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, IDLE,                             "reset_idle"};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, mk(1, 1, 1, 0, 0, 0, 0, 1, 1),  "first_tick"};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, mk(1, 1, 1, 0, 0, 0, 0, 0, 0),  "hold_a"};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, mk(1, 1, 1, 0, 0, 0, 0, 0, 0),  "hold_b"};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, mk(1, 1, 1, 1, 0, 0, 0, 0, 0),  "pixel1"};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, IDLE,                             "disable"};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, mk(1, 1, 1, 0, 0, 0, 0, 1, 1),  "reenable"};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, mk(1, 1, 1, 1, 0, 0, 0, 0, 0),  "pixel1_b"};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, IDLE,                             "reset_prio"};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, mk(1, 1, 1, 0, 0, 0, 0, 1, 1),  "after_reset"};
        tbl[10] = '{1'b0, 1'b1, 1'b1, mk(1, 1, 1, 1, 0, 0, 0, 0, 0),  "pixel1_c"};

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].r, tbl[i].ce, tbl[i].en);
            chk(tbl[i].name, 32'(out0()), 32'(tbl[i].exp));
        end

        // Full speed: frame period, hsync window, de width
        step(1'b1, 1'b0, 1'b0);
        fs_first = -1; fs_second = -1; de_cnt = 0; lr_cnt = 0; hs_pat = '0;
        for (int i = 0; i < 2 * FT; i++) begin
            step(1'b0, 1'b1, 1'b1);
            if (fs0) begin
                if (fs_first < 0) fs_first = i;
                else if (fs_second < 0) fs_second = i;
            end
            if (i < HT) begin
                hs_pat[i] = hs0;
                if (de0) de_cnt++;
            end
`ifdef VGA_LINE_REQ_EN
            if (lr0) lr_cnt++;
`endif
        end
        chk("first_fs_index", 32'(fs_first), 32'd0);
        chk("frame_period", 32'(fs_second - fs_first), 32'(FT));
        chk("hsync_window", 32'(hs_pat), 32'h63FF);
        chk("de_width", 32'(de_cnt), 32'd8);
`ifdef VGA_LINE_REQ_EN
        chk("line_req_count", 32'(lr_cnt), 32'd8);
`endif

        // pix_ce every third clk: strobes stay one clk wide
        step(1'b1, 1'b0, 1'b0);
        fs_cnt = 0; ls_cnt = 0;
        for (int i = 0; i < 3 * FT; i++) begin
            step(1'b0, (i % 3) == 0, 1'b1);
            if (fs0) fs_cnt++;
            if (ls0) ls_cnt++;
        end
        chk("sparse_fs_cycles", 32'(fs_cnt), 32'd1);
        chk("sparse_ls_cycles", 32'(ls_cnt), 32'd4);

        // Reset with counters at h=5, v=2
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2 * HT + 5; i++) step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk("midreset_idle", 32'(out0()), 32'(IDLE));
        step(1'b0, 1'b1, 1'b1);
        chk("midreset_fs", 32'(fs0), 32'd1);
        chk("midreset_xy", 32'({x0, y0}), 32'd0);
        step(1'b0, 1'b1, 1'b1);
        chk("midreset_x1", 32'(x0), 32'd1);

        // Enable dropped for 20 ticks mid-frame
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1);
        idle_bad = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (out0() !== IDLE) idle_bad++;
        end
        chk("disabled_idle", 32'(idle_bad), 32'd0);
        step(1'b0, 1'b1, 1'b1);
        chk("reenable_fs", 32'(fs0), 32'd1);
        for (int i = 1; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b1);
            chk("reenable_x", 32'(x0), 32'(i));
        end

        // Randomized traffic against the reference
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(99) == 0);
            ce = ($urandom_range(9) < 6);
            en = ($urandom_range(19) != 0);
            step(r, ce, en);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator; next generation of the fixed 640x480 sync generator.
- Any mode is set by parameters: active, front porch, sync and back porch per axis, plus sync polarities.
- Adds a pixel clock-enable, a run enable, line/frame strobes, blanking flags and a programmable output pipeline delay, so sync lines up with downstream pixel-fetch latency.
- Sits between the clock/reset block and the Game Boy framebuffer scaler/colour output stage.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- H_POL, 0, hsync active level
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- V_POL, 0, vsync active level
- CW, 11, counter and coordinate width; must satisfy 2^CW >= H_TOTAL and 2^CW >= V_TOTAL
- PIPE_DELAY, 0, extra pix_ce-clocked register stages on all outputs (0..15)

Ports:
- clk  in  1  pixel-domain clock
- reset  in  1  reset, synchronous, active-high
- pix_ce  in  1  pixel tick; all state advances only on clk edges with pix_ce=1
- enable  in  1  run enable; low holds the raster at origin
- hsync  out  1  horizontal sync, polarity H_POL
- vsync  out  1  vertical sync, polarity V_POL
- de  out  1  data enable, high in the active region
- x  out  CW  active column; 0 when de=0
- y  out  CW  active row; 0 when de=0
- hblank  out  1  h_cnt >= H_ACTIVE
- vblank  out  1  v_cnt >= V_ACTIVE
- line_start  out  1  one-clk strobe at the first pixel of each active line
- frame_start  out  1  one-clk strobe at pixel (0,0)

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL defined likewise.
- Counter order per axis: active [0, ACTIVE-1], then FP, then SYNC, then BP.
- hsync is active when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC. vsync uses the same rule on v_cnt.
- Counters: on a tick (pix_ce=1 and enable=1), h_cnt increments.
  - At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - At V_TOTAL-1 (with h at H_TOTAL-1), v_cnt wraps to 0.
  - No other wrap values.
- enable=0 on a pix_ce edge: h_cnt=v_cnt=0, and the decode stage loads the idle value. enable=1 resumes at (0,0).
- pix_ce=0: counters and all pipeline stages hold. Strobes are forced to 0 on every clk edge that is not a tick.
- Decode stage: one register stage loads from (h_cnt, v_cnt) on each tick.
  - Idle value: syncs inactive, de=0, x=y=0, blank flags=1, strobes=0.
  - The decode of counter state (h,v) appears on the outputs 1+PIPE_DELAY ticks after the tick that presented (h,v).
  - All outputs share identical latency.
- Strobes: line_start decodes h=0 and v<V_ACTIVE; frame_start decodes h=0 and v=0.
  - Each strobe is high for exactly the one clk cycle after its tick, even with sparse pix_ce.
  - Strobes are not re-asserted while pix_ce is low.
- Reset: counters 0 and all pipeline stages at the idle value.
  - Outputs on the cycle after reset: hsync=~H_POL, vsync=~V_POL, de=0, x=y=0, hblank=vblank=1, line_start=frame_start=0.
  - reset has priority over pix_ce/enable.
  - Reset mid-frame returns immediately to origin; no partial sync pulse is stretched.
- Simultaneous end of line and end of frame: both counters wrap on the same tick.
- Elaboration error if any porch or sync width is 0, or if the totals exceed 2^CW.

Optional Feature:
- Macro: VGA_LINE_REQ_EN.
- Defined: adds parameter LINE_LEAD (default 8) and outputs line_req (1) and line_req_y (CW).
  - line_req is a one-clk strobe issued LINE_LEAD ticks before line_start of every active line; this includes line 0, whose request is issued from the previous frame's last line.
  - line_req_y gives the row about to be displayed; it is held until the next line_req.
  - LINE_LEAD must be <= H_TOTAL-H_ACTIVE.
- Undefined: ports and logic are absent; base behaviour is unchanged.

Test Plan:
- Small mode H 8/2/3/2 (H_TOTAL 15), V 4/1/2/1 (V_TOTAL 8), H_POL=V_POL=0, pix_ce=1, PIPE_DELAY=0 -> per line: de high 8 cycles; hsync low cycles 10..12 of each 15-cycle line; vsync low during lines 5..6; frame period 120 cycles; frame_start once per 120 cycles.
- Same mode, pix_ce high every 3rd clk -> all periods triple; line_start and frame_start remain exactly 1 clk wide; outputs hold between ticks.
- PIPE_DELAY=3 versus 0 under the same stimulus -> every output identical but delayed by 3 ticks; x/y/de/hsync stay mutually aligned.
- Assert reset at h=5, v=2 -> next cycle: hsync=1, vsync=1, de=0, x=y=0; first frame_start arrives on the tick after reset release; counting restarts at (0,0).
- Drop enable for 20 ticks mid-frame -> idle outputs throughout; on re-enable, frame_start follows 1 tick later and x counts 0..7.
- VGA_LINE_REQ_EN, LINE_LEAD=4 -> line_req 4 ticks before each line_start; line_req_y = 0,1,2,3; 4 strobes per frame; none in vblank lines except the one preceding line 0.
